// File: rtl/pm_boot_loader_if.sv
// Host byte stream and program-memory write port of the boot loader.
interface pm_boot_loader_if #(
  parameter int PMA_SIZE = 16,
  parameter int PMD_SIZE = 32
);
  logic [7:0]          host_dt;
  logic                host_valid;
  logic                host_ready;
  logic                pm_ld_wen;
  logic [PMA_SIZE-1:0] pm_ld_add;
  logic [PMD_SIZE-1:0] pm_ld_dt;

  modport master (
    output host_dt, host_valid,
    input  host_ready, pm_ld_wen, pm_ld_add, pm_ld_dt
  );

  modport slave (
    input  host_dt, host_valid,
    output host_ready, pm_ld_wen, pm_ld_add, pm_ld_dt
  );
endinterface

// File: rtl/pm_boot_loader.sv
// Loads program memory from a host byte stream (16-bit BE word count, payload, sum byte),
// then releases the core. Optional idle watchdog enabled by defining BOOT_TIMEOUT_EN.
module pm_boot_loader #(
  parameter int PMA_SIZE       = 16,
  parameter int PMD_SIZE       = 32,
  parameter int BASE_ADD       = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             boot_start,
  pm_boot_loader_if.slave  bus,
  output logic             core_reset,
  output logic             boot_busy,
  output logic             boot_done,
  output logic             boot_err,
  output logic [1:0]       boot_err_code
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [7:0]          BYTE_LAST = 8'(PMD_SIZE / 8 - 1);
  localparam logic [32:0]         MAX_WORDS = (33'd1 << PMA_SIZE) - 33'(BASE_ADD);
  localparam logic [PMA_SIZE-1:0] ADD_BASE  = PMA_SIZE'(BASE_ADD);
  localparam logic [PMA_SIZE-1:0] ADD_ONE   = PMA_SIZE'(1);

  if ((PMD_SIZE % 8) != 0 || PMD_SIZE < 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("pm_boot_loader: illegal parameterisation");
  end

  function automatic logic [7:0] sum_add(input logic [7:0] sum, input logic [7:0] dt);
    return sum + dt;
  endfunction

  state_t              state_r, state_nx_s;
  logic [1:0]          code_nx_s;
  logic [7:0]          hdr_hi_r;
  logic [15:0]         words_left_r;
  logic [7:0]          byte_cnt_r;
  logic [PMD_SIZE-1:0] asm_r;
  logic [7:0]          sum_r;
  logic [PMA_SIZE-1:0] addr_r;
  logic                accept_s, start_s, last_byte_s, timeout_s, busy_nx_s;
  logic [15:0]         n_s;
  logic [PMD_SIZE-1:0] asm_s;

  assign accept_s    = bus.host_valid & bus.host_ready;
  assign start_s     = boot_start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERR));
  assign last_byte_s = (byte_cnt_r == BYTE_LAST);
  assign n_s         = {hdr_hi_r, bus.host_dt};
  assign asm_s       = PMD_SIZE'({asm_r, bus.host_dt});
  assign busy_nx_s   = (state_nx_s == HDR_HI) | (state_nx_s == HDR_LO) |
                       (state_nx_s == DATA) | (state_nx_s == CHK);

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] idle_cnt_r;

  // Counts busy cycles that pass without a byte transfer.
  always_ff @(posedge clk) begin
    if (reset || accept_s || start_s || !boot_busy) begin
      idle_cnt_r <= 32'd0;
    end else begin
      idle_cnt_r <= idle_cnt_r + 32'd1;
    end
  end

  assign timeout_s = (idle_cnt_r == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and error-code decode.
  always_comb begin
    state_nx_s = state_r;
    code_nx_s  = boot_err_code;
    case (state_r)
      IDLE: begin
        if (boot_start) state_nx_s = HDR_HI;
        else            state_nx_s = IDLE;
      end
      HDR_HI: begin
        if (accept_s) begin
          state_nx_s = HDR_LO;
        end else if (timeout_s) begin
          state_nx_s = ERR;
          code_nx_s  = 2'b11;
        end else begin
          state_nx_s = HDR_HI;
        end
      end
      HDR_LO: begin
        if (accept_s) begin
          if ({17'd0, n_s} > MAX_WORDS) begin
            state_nx_s = ERR;
            code_nx_s  = 2'b10;
          end else if (n_s == 16'd0) begin
            state_nx_s = CHK;
          end else begin
            state_nx_s = DATA;
          end
        end else if (timeout_s) begin
          state_nx_s = ERR;
          code_nx_s  = 2'b11;
        end else begin
          state_nx_s = HDR_LO;
        end
      end
      DATA: begin
        if (accept_s) begin
          if (last_byte_s && words_left_r == 16'd1) state_nx_s = CHK;
          else                                      state_nx_s = DATA;
        end else if (timeout_s) begin
          state_nx_s = ERR;
          code_nx_s  = 2'b11;
        end else begin
          state_nx_s = DATA;
        end
      end
      CHK: begin
        if (accept_s) begin
          if (bus.host_dt == sum_r) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = ERR;
            code_nx_s  = 2'b01;
          end
        end else if (timeout_s) begin
          state_nx_s = ERR;
          code_nx_s  = 2'b11;
        end else begin
          state_nx_s = CHK;
        end
      end
      DONE, ERR: begin
        if (boot_start) begin
          state_nx_s = HDR_HI;
          code_nx_s  = 2'b00;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
        code_nx_s  = 2'b00;
      end
    endcase
  end

  // State register and status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      bus.host_ready <= 1'b0;
      boot_busy      <= 1'b0;
      core_reset     <= 1'b1;
      boot_done      <= 1'b0;
      boot_err       <= 1'b0;
      boot_err_code  <= 2'b00;
    end else begin
      state_r        <= state_nx_s;
      bus.host_ready <= busy_nx_s;
      boot_busy      <= busy_nx_s;
      core_reset     <= (state_nx_s != DONE);
      boot_done      <= (state_nx_s == DONE);
      boot_err       <= (state_nx_s == ERR);
      boot_err_code  <= code_nx_s;
    end
  end

  // Header capture, word assembly, checksum and PM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_hi_r      <= 8'd0;
      words_left_r  <= 16'd0;
      byte_cnt_r    <= 8'd0;
      asm_r         <= '0;
      sum_r         <= 8'd0;
      addr_r        <= ADD_BASE;
      bus.pm_ld_wen <= 1'b0;
      bus.pm_ld_add <= '0;
      bus.pm_ld_dt  <= '0;
    end else begin
      bus.pm_ld_wen <= 1'b0;
      if (start_s) begin
        byte_cnt_r <= 8'd0;
        asm_r      <= '0;
        sum_r      <= 8'd0;
        addr_r     <= ADD_BASE;
      end else if (accept_s) begin
        case (state_r)
          HDR_HI: hdr_hi_r <= bus.host_dt;
          HDR_LO: words_left_r <= n_s;
          DATA: begin
            sum_r <= sum_add(sum_r, bus.host_dt);
            asm_r <= asm_s;
            if (last_byte_s) begin
              byte_cnt_r    <= 8'd0;
              words_left_r  <= words_left_r - 16'd1;
              bus.pm_ld_wen <= 1'b1;
              bus.pm_ld_add <= addr_r;
              bus.pm_ld_dt  <= asm_s;
              addr_r        <= addr_r + ADD_ONE;
            end else begin
              byte_cnt_r <= byte_cnt_r + 8'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pm_boot_loader.sv
// Self-checking bench for pm_boot_loader: image table plus hand-written corner cases,
// with a scoreboard queue of expected PM writes.
module tb_pm_boot_loader;
  localparam int PMA   = 4;
  localparam int PMD   = 32;
  localparam int MAX_N = 1 << PMA;

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  chk;
    int          gap;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           boot_start;
  logic           core_reset, boot_busy, boot_done, boot_err;
  logic [1:0]     boot_err_code;
  int             checks   = 0;
  int             failures = 0;
  logic [PMA+PMD-1:0] exp_q[$];
  logic [PMA-1:0] exp_add;
  vec_t           vecs[5];

  pm_boot_loader_if #(.PMA_SIZE(PMA), .PMD_SIZE(PMD)) bus ();

  pm_boot_loader #(
    .PMA_SIZE(PMA), .PMD_SIZE(PMD), .BASE_ADD(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .boot_start(boot_start), .bus(bus),
    .core_reset(core_reset), .boot_busy(boot_busy), .boot_done(boot_done),
    .boot_err(boot_err), .boot_err_code(boot_err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e, input logic [1:0] c,
                             input logic cr, input logic b, input logic r);
    check({tag, "_done"}, 64'(boot_done), 64'(d));
    check({tag, "_err"}, 64'(boot_err), 64'(e));
    check({tag, "_code"}, 64'(boot_err_code), 64'(c));
    check({tag, "_core_reset"}, 64'(core_reset), 64'(cr));
    check({tag, "_busy"}, 64'(boot_busy), 64'(b));
    check({tag, "_ready"}, 64'(bus.host_ready), 64'(r));
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : mon
    logic [PMA+PMD-1:0] e;
    if (bus.pm_ld_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: add 0x%0h data 0x%0h, none expected",
                 bus.pm_ld_add, bus.pm_ld_dt);
      end else begin
        e = exp_q.pop_front();
        check("pm_write", 64'({bus.pm_ld_add, bus.pm_ld_dt}), 64'(e));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.host_dt    = b;
    bus.host_valid = 1'b1;
    while (bus.host_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL ready_wait: host_ready stayed low for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    bus.host_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int b = 0; b < 4; b++) begin
      if (b == 2 && gap > 0) repeat (gap) @(negedge clk);
      if (b == 3) begin
        exp_q.push_back({exp_add, w});
        exp_add = exp_add + 1'b1;
      end
      send_byte(w[31-8*b -: 8]);
    end
  endtask

  task automatic start_boot(input string tag);
    @(negedge clk);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    exp_add = '0;
    check_flags({tag, "_start"}, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] ws[2];
    string tag;
    tag   = $sformatf("vec%0d", idx);
    ws[0] = v.w0;
    ws[1] = v.w1;
    start_boot(tag);
    send_byte(v.n[15:8]);
    send_byte(v.n[7:0]);
    if (v.n <= 16'(MAX_N)) begin
      for (int w = 0; w < int'(v.n); w++) send_word(ws[w], (w == 0) ? v.gap : 0);
      send_byte(v.chk);
    end
    @(negedge clk);
    check_flags(tag, v.exp_done, v.exp_err, v.exp_code, !v.exp_done, 1'b0, 1'b0);
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] w;
    logic [7:0]  sum;
    vecs[0] = '{16'd2,  32'h11223344, 32'hAABBCCDD, 8'hB8, 0, 1'b1, 1'b0, 2'b00};
    vecs[1] = '{16'd2,  32'h11223344, 32'hAABBCCDD, 8'hB9, 0, 1'b0, 1'b1, 2'b01};
    vecs[2] = '{16'd0,  32'h0,        32'h0,        8'h00, 0, 1'b1, 1'b0, 2'b00};
    vecs[3] = '{16'd2,  32'h11223344, 32'hAABBCCDD, 8'hB8, 5, 1'b1, 1'b0, 2'b00};
    vecs[4] = '{16'd17, 32'h0,        32'h0,        8'h00, 0, 1'b0, 1'b1, 2'b10};

    reset = 1'b1; boot_start = 1'b0; bus.host_valid = 1'b0; bus.host_dt = 8'h00;
    exp_add = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_flags("reset", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("reset_wen", 64'(bus.pm_ld_wen), 64'd0);
    check("reset_add", 64'(bus.pm_ld_add), 64'd0);
    check("reset_dt", 64'(bus.pm_ld_dt), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Largest image that fits: 16 words filling addresses 0..15.
    start_boot("full");
    send_byte(8'h00);
    send_byte(8'h10);
    sum = 8'h00;
    for (int i = 0; i < MAX_N; i++) begin
      w   = $urandom;
      sum = sum + w[31:24] + w[23:16] + w[15:8] + w[7:0];
      send_word(w, 0);
    end
    send_byte(sum);
    @(negedge clk);
    check_flags("full", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("full_pending_writes", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a word: nothing written, outputs back to reset values.
    start_boot("midrst");
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_flags("midrst", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("midrst_wen", 64'(bus.pm_ld_wen), 64'd0);
    check("midrst_add", 64'(bus.pm_ld_add), 64'd0);
    check("midrst_dt", 64'(bus.pm_ld_dt), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_flags("midrst_idle", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

    // Full reload after reset, with a boot_start pulse mid-load that must be ignored.
    start_boot("reload");
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'h11223344, 0);
    @(negedge clk);
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
    send_word(32'hAABBCCDD, 0);
    send_byte(8'hB8);
    @(negedge clk);
    check_flags("reload", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("reload_pending_writes", 64'(exp_q.size()), 64'd0);

    // Host stall in the middle of a word.
    start_boot("stall");
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
`ifdef BOOT_TIMEOUT_EN
    repeat (14) @(posedge clk);
    #1;
    check("stall_early_err", 64'(boot_err), 64'd0);
    for (int i = 0; i < 8 && boot_err !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    check_flags("timeout", 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
`else
    repeat (100) @(negedge clk);
    check_flags("stall_wait", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({exp_add, 32'h01020304});
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h0A);
    @(negedge clk);
    check_flags("stall_done", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
`endif
    check("stall_pending_writes", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pm_boot_loader.md
Name: pm_boot_loader

Overview:
- Sits upstream of the core: loads program memory from a host byte stream before the program sequencer starts fetching.
- Parses a small image header, assembles bytes into PM words and issues PM write strobes.
- Checks a payload checksum, then releases the core from reset.
- Holds the core in reset whenever no valid image has been loaded.

Parameters:
PMA_SIZE, 16, program memory address width.
PMD_SIZE, 32, program memory word width; must be a multiple of 8.
BASE_ADD, 0, PM address of the first loaded word.
TIMEOUT_CYCLES, 1024, idle-byte watchdog limit; used only with BOOT_TIMEOUT_EN.

Ports:
clk  input  1  core clock; all logic on rising edge
reset  input  1  synchronous, active-high
boot_start  input  1  single-cycle request to begin a load
host_dt  input  8  host byte
host_valid  input  1  host byte valid
host_ready  output  1  loader accepts a byte this cycle
pm_ld_wen  output  1  PM write strobe, one cycle per word
pm_ld_add  output  PMA_SIZE  PM write address
pm_ld_dt  output  PMD_SIZE  PM write data
core_reset  output  1  reset to the core; high unless an image is loaded
boot_busy  output  1  load in progress
boot_done  output  1  image loaded and verified
boot_err  output  1  load failed
boot_err_code  output  2  01 checksum, 10 length, 11 timeout, 00 none

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: host_ready 0, pm_ld_wen 0, pm_ld_add 0, pm_ld_dt 0, core_reset 1, boot_busy 0, boot_done 0, boot_err 0, boot_err_code 00. FSM enters IDLE.
- Byte transfer: a byte is accepted on a clock edge where host_valid and host_ready are both high. Throughput is at most one byte per cycle.
- host_ready is a decode of the state: high only in HDR_HI, HDR_LO, DATA and CHK.
- Image format: word count N as 16 bits big-endian (HDR_HI, then HDR_LO), then N×(PMD_SIZE/8) payload bytes, each word MSB-first, then one checksum byte.
- Checksum: sum of all payload bytes mod 256. Header bytes are excluded.
- State transitions:
  - IDLE: boot_start -> HDR_HI.
  - HDR_HI -> HDR_LO on byte acceptance.
  - HDR_LO on acceptance: N > 2^PMA_SIZE − BASE_ADD -> ERR with code 10; N = 0 -> CHK; otherwise -> DATA.
  - DATA: bytes shift into an assembly register. The cycle after the last byte of a word is accepted, pm_ld_wen = 1 with the registered pm_ld_add/pm_ld_dt. The address starts at BASE_ADD and increments after each write. The next byte may be accepted in that same cycle. After the Nth word's final byte -> CHK.
  - CHK on acceptance: byte equals running sum -> DONE, else -> ERR with code 01.
  - DONE: boot_done = 1, core_reset = 0, registered, one cycle after the checksum byte.
  - ERR: boot_err = 1, code held, core_reset = 1.
- Output flags:
  - boot_busy is high in HDR_HI, HDR_LO, DATA and CHK.
  - core_reset is high in every state except DONE, including while busy after a restart.
- boot_start handling: ignored while busy. In DONE or ERR it clears done/err/code, reasserts core_reset next cycle, resets the address and sum, and goes to HDR_HI.
- Reset mid-load: all outputs return to reset values next cycle, the FSM goes to IDLE, a partially assembled word is discarded, and no write is issued.
- No address wrap: the length check guarantees the final address is ≤ 2^PMA_SIZE − 1.

Optional Feature:
- BOOT_TIMEOUT_EN defined:
  - An idle counter clears on each accepted byte and on entry to HDR_HI.
  - It counts cycles in HDR_HI/HDR_LO/DATA/CHK with no acceptance.
  - On reaching TIMEOUT_CYCLES it goes to ERR with code 11.
- Undefined: no counter; the loader waits indefinitely and code 11 never occurs.

Test Plan:
- Normal load (PMD_SIZE=32, BASE_ADD=0): boot_start; bytes 00 02, 11 22 33 44, AA BB CC DD, checksum B8 -> pm_ld_wen pulses at add 0 with 0x11223344 and add 1 with 0xAABBCCDD; boot_done=1, core_reset=0.
- Same image with checksum B9 -> both writes occur; boot_err=1, code 01, core_reset stays 1, boot_done=0.
- Empty image: 00 00, checksum 00 -> no pm_ld_wen; boot_done=1.
- Length error (PMA_SIZE=4): header 00 11 (N=17) -> ERR with code 10 the cycle after the second header byte; host_ready=0; no writes.
- Gapped host_valid with a 5-cycle gap mid-word -> identical writes to the normal case. Reset asserted after 3 payload bytes -> all outputs at reset values, no write, FSM in IDLE; a following boot_start plus a full image loads correctly.
- With BOOT_TIMEOUT_EN and TIMEOUT_CYCLES=16: stall 16 cycles in DATA -> boot_err, code 11. Without the macro: no error after 100 stall cycles, and the load completes once bytes resume.
